// File: rtl/pong_match_ctrl.sv
// Match/round sequencer for the pong ball block: serve delay, play, point hold, match over.
// Optional PLAY pause with an extra in_pause port is compiled in by defining PONG_MATCH_PAUSE_EN.
module pong_match_ctrl #(
    parameter int WIN_POINTS  = 7,
    parameter int SERVE_DELAY = 60,
    parameter int POINT_HOLD  = 90,
    parameter int CNT_W       = 8
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_ani_stb,
    input  logic       in_serve,
    input  logic       in_left_score,
    input  logic       in_right_score,
`ifdef PONG_MATCH_PAUSE_EN
    input  logic       in_pause,
`endif
    output logic       out_start,
    output logic       out_ball_reset,
    output logic       out_animate,
    output logic [3:0] out_left_points,
    output logic [3:0] out_right_points,
    output logic [1:0] out_winner,
    output logic [2:0] out_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    // A zero-frame delay or hold behaves like a single frame.
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'((SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((POINT_HOLD > 0) ? POINT_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       WIN_P      = 4'(WIN_POINTS);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       left_pts, left_n, right_pts, right_n;
    logic [1:0]       winner, winner_n;
    logic             start_n, ball_reset_n;
    logic [1:0]       serve_sr, left_sr, right_sr;
    logic             serve_rise, left_rise, right_rise;
    logic             hold_play;

    // Bit 0 is the sampled input, bit 1 the previous sample.
    assign serve_rise = serve_sr[0] & ~serve_sr[1];
    assign left_rise  = left_sr[0] & ~left_sr[1];
    assign right_rise = right_sr[0] & ~right_sr[1];

`ifdef PONG_MATCH_PAUSE_EN
    logic [1:0] pause_sr;
    logic       pause_rise, paused, paused_n;
    assign pause_rise = pause_sr[0] & ~pause_sr[1];
    assign hold_play  = paused;
`else
    assign hold_play  = 1'b0;
`endif

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state          <= IDLE;
            cnt            <= '0;
            left_pts       <= '0;
            right_pts      <= '0;
            winner         <= '0;
            out_start      <= 1'b0;
            out_ball_reset <= 1'b0;
            serve_sr       <= '0;
            left_sr        <= '0;
            right_sr       <= '0;
`ifdef PONG_MATCH_PAUSE_EN
            pause_sr       <= '0;
            paused         <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            left_pts       <= left_n;
            right_pts      <= right_n;
            winner         <= winner_n;
            out_start      <= start_n;
            out_ball_reset <= ball_reset_n;
            serve_sr       <= {serve_sr[0], in_serve};
            left_sr        <= {left_sr[0], in_left_score};
            right_sr       <= {right_sr[0], in_right_score};
`ifdef PONG_MATCH_PAUSE_EN
            pause_sr       <= {pause_sr[0], in_pause};
            paused         <= paused_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        left_n       = left_pts;
        right_n      = right_pts;
        winner_n     = winner;
        start_n      = 1'b0;
        ball_reset_n = 1'b0;
        out_animate  = 1'b0;
        case (state)
            IDLE: begin
                if (serve_rise) begin
                    ball_reset_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = SERVE;
                end
            end
            SERVE: begin
                out_animate = 1'b1;
                if (in_ani_stb) begin
                    if (cnt >= SERVE_LAST) begin
                        start_n = 1'b1;
                        cnt_n   = '0;
                        state_n = PLAY;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            PLAY: begin
                out_animate = ~hold_play;
                if (!hold_play) begin
                    // Simultaneous scores are a replay: no point, straight to hold.
                    if (left_rise && right_rise) begin
                        cnt_n   = '0;
                        state_n = POINT;
                    end else if (left_rise) begin
                        left_n = left_pts + 4'd1;
                        cnt_n  = '0;
                        if (left_n == WIN_P) begin
                            winner_n = 2'b01;
                            state_n  = OVER;
                        end else begin
                            state_n = POINT;
                        end
                    end else if (right_rise) begin
                        right_n = right_pts + 4'd1;
                        cnt_n   = '0;
                        if (right_n == WIN_P) begin
                            winner_n = 2'b10;
                            state_n  = OVER;
                        end else begin
                            state_n = POINT;
                        end
                    end
                end
            end
            POINT: begin
                out_animate = 1'b1;
                if (serve_rise) begin
                    cnt_n   = '0;
                    state_n = SERVE;
                end else if (in_ani_stb) begin
                    if (cnt >= HOLD_LAST) begin
                        cnt_n   = '0;
                        state_n = SERVE;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            OVER: begin
                if (serve_rise) begin
                    left_n       = '0;
                    right_n      = '0;
                    winner_n     = '0;
                    ball_reset_n = 1'b1;
                    cnt_n        = '0;
                    state_n      = SERVE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
`ifdef PONG_MATCH_PAUSE_EN
        paused_n = paused;
        if (state == PLAY && pause_rise) paused_n = ~paused;
        if (state_n != PLAY) paused_n = 1'b0;
`endif
    end

    assign out_left_points  = left_pts;
    assign out_right_points = right_pts;
    assign out_winner       = winner;
    assign out_state        = state;
endmodule
